// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide sequencer for MULT/MULTU/DIV/DIVU.
// Borrows the shared ALU adder (unsigned mode) once per iteration; owns HI/LO.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_sign,
  input  logic [31:0] add_s,
  input  logic        add_v,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SETUP, ITER, FIX} state_t;

  // Handshake: start is accepted only while busy=0 (IDLE, including the done
  // cycle); done is a single-cycle pulse with HI/LO already updated.
  state_t      state;
  logic [1:0]  op_r;
  logic [31:0] rs_r;
  logic [31:0] rt_r;
  logic [31:0] ph;     // P_hi for multiply, partial remainder R for divide
  logic [31:0] pl;     // P_lo for multiply, quotient/dividend Q for divide
  logic [31:0] m;      // multiplicand M, or negated divisor ND
  logic        neg_q;
  logic        neg_r;
  logic [4:0]  cnt;

  logic        is_div;
  logic        is_signed;
  logic [31:0] abs_rs;
  logic [31:0] abs_rt;
  logic [31:0] r_shift;
  logic        ge;
  logic [63:0] prod_fix;

  assign add_sign = 1'b0;

  always_comb begin
    is_div    = op_r[1];
    is_signed = ~op_r[0];
    abs_rs    = (is_signed && rs_r[31]) ? (~rs_r + 32'd1) : rs_r;
    abs_rt    = (is_signed && rt_r[31]) ? (~rt_r + 32'd1) : rt_r;
    r_shift   = {ph[30:0], pl[31]};
    // Bit shifted out of R counts as "R' >= divisor" even if the adder doesn't carry
    ge        = ph[31] | add_v;
    prod_fix  = neg_q ? (~{ph, pl} + 64'd1) : {ph, pl};
    add_a     = 32'd0;
    add_b     = 32'd0;
    if (state == ITER) begin
      if (is_div) begin
        add_a = r_shift;
        add_b = m;
      end else begin
        add_a = ph;
        add_b = pl[0] ? m : 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_r  <= 2'd0;
      rs_r  <= 32'd0;
      rt_r  <= 32'd0;
      ph    <= 32'd0;
      pl    <= 32'd0;
      m     <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= 5'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_r  <= op;
            rs_r  <= rs;
            rt_r  <= rt;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          neg_q <= is_signed & (rs_r[31] ^ rt_r[31]);
          neg_r <= is_signed & rs_r[31];
          cnt   <= 5'd31;
          ph    <= 32'd0;
          if (is_div) begin
            if (rt_r == 32'd0) begin
              hi    <= rs_r;
              lo    <= 32'hFFFF_FFFF;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              pl    <= abs_rs;
              m     <= ~abs_rt + 32'd1;
              state <= ITER;
            end
          end else begin
            pl    <= abs_rt;
            m     <= abs_rs;
            state <= ITER;
          end
        end
        ITER: begin
          if (is_div) begin
            ph <= ge ? add_s : r_shift;
            pl <= {pl[30:0], ge};
          end else begin
            ph <= {add_v, add_s[31:1]};
            pl <= {add_s[0], pl[31:1]};
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo <= neg_q ? (~pl + 32'd1) : pl;
            hi <= neg_r ? (~ph + 32'd1) : ph;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative HI/LO multiply/divide sequencer for the MIPS core's MULT/MULTU/DIV/DIVU instructions. It does not contain its own 32-bit adder. It drives the shared ALU `ADD` unit in unsigned mode once per iteration and uses its sum and carry (V) flag. It sits beside the ALU in the EX stage, holds the architectural HI/LO registers, and exposes a start/busy/done handshake that the pipeline control uses to stall on MFHI/MFLO.

## Interface
- No parameters; the datapath width is fixed at 32.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU (funct[1:0] of 0x18–0x1B).
- `rs`, `rt`  in  32 each  operands: multiplicand/multiplier, or dividend/divisor.
- `hi_we`, `lo_we`  in  1 each  MTHI/MTLO write enables.
- `wdata`  in  32  MTHI/MTLO data.
- `add_a`, `add_b`  out  32 each  operands to the shared adder.
- `add_sign`  out  1  adder Sign input; constant 0.
- `add_s`  in  32  adder sum; combinational, same cycle.
- `add_v`  in  1  adder V flag; in unsigned mode this is the carry-out.
- `hi`, `lo`  out  32 each  architectural HI/LO.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **States:** IDLE, SETUP, ITER, FIX.
- **Reset:** state IDLE; `hi`/`lo` = 0; `busy` = 0; `done` = 0; iteration counter = 0; all work registers = 0.
- **IDLE**
  - `start`=1: latch `op`, `rs`, `rt`; go to SETUP.
  - `hi_we`/`lo_we` write `wdata` in IDLE only. They are ignored in all other states.
  - Write and start in the same cycle: the write takes effect, and the operation later overwrites HI/LO.
- **SETUP**
  - For signed ops, take magnitudes (two's-complement negate when bit 31 is set). Record the result-sign flags:
    - product/quotient negative = sign(rs) XOR sign(rt);
    - remainder negative = sign(rs).
  - Multiply: P_hi = 0, P_lo = |rt|, M = |rs|.
  - Divide: R = 0, Q = |rs|, ND = −|rt| (that is, ~|rt|+1).
  - Load counter = 31 and go to ITER.
  - Divide with rt = 0: skip ITER. Set `hi` = rs (raw), `lo` = 0xFFFFFFFF, pulse `done`, go to IDLE.
- **ITER**, 32 cycles; counter decrements and the state leaves after count 0.
  - Multiply:
    - `add_a` = P_hi; `add_b` = P_lo[0] ? M : 0.
    - {P_hi, P_lo} ← {`add_v`, `add_s`, P_lo} >> 1 (65-bit shift, low bit dropped).
  - Divide:
    - top = R[31]; R' = {R[30:0], Q[31]}.
    - `add_a` = R'; `add_b` = ND.
    - ge = top | `add_v`.
    - R ← ge ? `add_s` : R'; Q ← {Q[30:0], ge}.
- **Adder outputs outside ITER:** `add_a` = `add_b` = 0 in IDLE, SETUP and FIX.
- **FIX**
  - Multiply, signed: negate the 64-bit {P_hi, P_lo} if negative. Write `hi` = P_hi, `lo` = P_lo.
  - Divide, signed: negate Q if the quotient is negative; negate R if the remainder is negative. Write `lo` = Q, `hi` = R.
  - Unsigned ops: no correction.
  - Set `done` for the next cycle and go to IDLE.
- **DIV 0x80000000 / 0xFFFFFFFF** needs no special case. Result: `lo` = 0x80000000, `hi` = 0.

## Timing
- Cycle 0 is the IDLE cycle in which `start`=1 is sampled.
- Normal operation:
  - SETUP = cycle 1; ITER = cycles 2–33; FIX = cycle 34.
  - `done`=1 and new `hi`/`lo` visible in cycle 35.
  - `busy`=1 in cycles 1–34; 0 otherwise.
- Divide by zero: `busy`=1 in cycle 1 only; `done`=1 and `hi`/`lo` visible in cycle 2.
- `done` is exactly one cycle wide. In the `done` cycle the block is IDLE and accepts a new `start` back-to-back.
- `start` while `busy`=1 is ignored; the operands are not re-latched.
- `reset` mid-operation aborts: next cycle is IDLE, `hi`/`lo` = 0, no `done` pulse.
- `hi`/`lo` change only on a FIX write, a divide-by-zero write, an IDLE MTHI/MTLO, or reset. Intermediate iteration values are never visible on `hi`/`lo`.

## Test plan
- **MULTU** rs=0xFFFFFFFF, rt=0xFFFFFFFF → `done` in cycle 35, `hi`=0xFFFFFFFE, `lo`=0x00000001. Check `busy` high for cycles 1–34 and `add_sign`=0 throughout.
- **MULT** rs=0xFFFFFFFD (−3), rt=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then **DIVU** rs=100, rt=7 issued in the `done` cycle → `lo`=14, `hi`=2 exactly 35 cycles later.
- **DIV** rs=0xFFFFFFF9 (−7), rt=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. **DIV** rs=0x80000000, rt=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **DIVU** rs=5, rt=0 → `done` in cycle 2, `hi`=5, `lo`=0xFFFFFFFF.
- `start` pulsed again at cycle 10 of a MULT, plus `hi_we` with `wdata`=0x1234 at cycle 12 → both ignored; the original result completes at cycle 35. MTLO 0xABCD in IDLE → `lo`=0xABCD next cycle.
- `reset` asserted at cycle 20 of a DIV → next cycle IDLE, `hi`=`lo`=0, `busy`=0, and no `done` pulse ever follows.
